// File: rtl/clk_period_meter.sv
// Measures a slow clock's period in in_clk cycles, with strobes and lock/loss status.
// Define DUTY_MEAS_EN to add the high_time output.
module clk_period_meter #(
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1000000,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             lost
`ifdef DUTY_MEAS_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        MEAS,
        ACQ,
        LOCK_S,
        LOST_S
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [7:0]       LOCK_C  = 8'(LOCK_COUNT);

    state_t           state;
    logic             sync1_q;
    logic             sync_q;
    logic             hist_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ref_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] diff;
    logic [7:0]       match;
    logic [7:0]       match_inc;
    logic             rise_det;
    logic             fall_det;
    logic             in_tol;
    logic             timeout_hit;
    logic             active;

    assign rise_det    = sync_q & ~hist_q;
    assign fall_det    = ~sync_q & hist_q;
    assign cnt_inc     = cnt + ONE;
    assign diff        = (cnt_inc >= ref_q) ? (cnt_inc - ref_q)
                                            : (ref_q - cnt_inc);
    assign in_tol      = (diff <= TOL_C);
    assign match_inc   = match + 8'd1;
    assign timeout_hit = (cnt == TO_LAST);
    assign active      = (state == MEAS) || (state == ACQ) ||
                         (state == LOCK_S);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            hist_q   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1_q  <= slow_clk;
            sync_q   <= sync1_q;
            hist_q   <= sync_q;
            rise_stb <= rise_det;
            fall_stb <= fall_det;
            if (rise_det)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt_inc;
        end
    end

    // A rise always takes priority over the timeout in the same cycle.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
            ref_q      <= '0;
            match      <= '0;
        end else begin
            period_vld <= 1'b0;
            if (rise_det) begin
                unique case (state)
                    IDLE, LOST_S: begin
                        state <= MEAS;
                        lost  <= 1'b0;
                    end
                    MEAS: begin
                        period     <= cnt_inc;
                        period_vld <= 1'b1;
                        ref_q      <= cnt_inc;
                        match      <= 8'd1;
                        if (LOCK_C == 8'd1) begin
                            state  <= LOCK_S;
                            locked <= 1'b1;
                        end else begin
                            state <= ACQ;
                        end
                    end
                    ACQ: begin
                        period     <= cnt_inc;
                        period_vld <= 1'b1;
                        if (in_tol) begin
                            match <= match_inc;
                            if (match_inc >= LOCK_C) begin
                                state  <= LOCK_S;
                                locked <= 1'b1;
                            end
                        end else begin
                            ref_q <= cnt_inc;
                            match <= 8'd1;
                        end
                    end
                    LOCK_S: begin
                        period     <= cnt_inc;
                        period_vld <= 1'b1;
                        if (!in_tol) begin
                            state  <= ACQ;
                            locked <= 1'b0;
                            ref_q  <= cnt_inc;
                            match  <= 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_hit && active) begin
                state  <= LOST_S;
                lost   <= 1'b1;
                locked <= 1'b0;
                match  <= '0;
            end
        end
    end

`ifdef DUTY_MEAS_EN
    logic seen_q;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q    <= 1'b0;
            high_time <= '0;
        end else begin
            if (rise_det)
                seen_q <= 1'b1;
            if (fall_det && seen_q)
                high_time <= cnt_inc;
        end
    end
`endif

endmodule
